// File: rtl/parking_time_recorder_pkg.sv
// Shared constants and types for the parking time recorder.
package parking_time_recorder_pkg;

  localparam int TW       = 8;
  localparam int SLOTS    = 8;
  localparam int SLOT_W   = 3;
  localparam int TICK_DIV = 4;

  // free_count value with an empty car park
  localparam logic [SLOT_W:0] FREE_RESET = (SLOT_W + 1)'(SLOTS);

  // One-cycle response pulses produced for every request edge
  typedef struct packed {
    logic enter_ack;
    logic enter_err;
    logic exit_valid;
    logic exit_err;
  } resp_t;

  // Population count over the widest supported occupancy vector
  function automatic logic [4:0] count_ones(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/parking_time_recorder_time_base.sv
// Prescaled free-running time base: now advances once every TICK_DIV cycles.
module parking_time_recorder_time_base #(
  parameter int TICK_DIV = 4,
  parameter int TW       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [TW-1:0] now,
  output logic          tick
);

  // One-bit prescaler when TICK_DIV is 1 so the compare stays well formed
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc;

  assign tick = (presc == PW'(TICK_DIV - 1));

  // Prescaler and time counter; now wraps modulo 2^TW
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      now   <= '0;
    end else if (tick) begin
      presc <= '0;
      now   <= now + TW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: rtl/parking_time_recorder.sv
// Records per-slot entry times and presents entry/exit timestamp pairs.
module parking_time_recorder
  import parking_time_recorder_pkg::*;
#(
  parameter int SLOTS    = parking_time_recorder_pkg::SLOTS,
  parameter int SLOT_W   = parking_time_recorder_pkg::SLOT_W,
  parameter int TICK_DIV = parking_time_recorder_pkg::TICK_DIV,
  parameter int TW       = parking_time_recorder_pkg::TW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enter_req,
  input  logic [SLOT_W-1:0] enter_slot,
  input  logic              exit_req,
  input  logic [SLOT_W-1:0] exit_slot,
  output logic              enter_ack,
  output logic              enter_err,
  output logic              exit_valid,
  output logic              exit_err,
  output logic [TW-1:0]     time_in,
  output logic [TW-1:0]     time_out,
  output logic [TW-1:0]     now,
  output logic [SLOTS-1:0]  occupied,
  output logic [SLOT_W:0]   free_count
);

  logic [TW-1:0]    slot_time [SLOTS];
  logic             enter_ok;
  logic             exit_ok;
  logic [SLOTS-1:0] occ_next;
  logic [SLOT_W:0]  free_next;
  resp_t            resp_next;
  resp_t            resp;
  // tick is exported by the time base for other timing consumers; the
  // recorder only needs the pre-edge value of now.
  logic             unused_tick;

  parking_time_recorder_time_base #(
    .TICK_DIV (TICK_DIV),
    .TW       (TW)
  ) u_time_base (
    .clk   (clk),
    .rst_n (rst_n),
    .now   (now),
    .tick  (unused_tick)
  );

  // Judge both requests against pre-edge occupancy. On a shared slot this
  // lets exactly one of enter/exit succeed, never both.
  // NOTE: every combinational output gets a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    enter_ok = enter_req && !occupied[enter_slot];
    exit_ok  = exit_req && occupied[exit_slot];
    occ_next = occupied;
    if (exit_ok)  occ_next[exit_slot]  = 1'b0;
    if (enter_ok) occ_next[enter_slot] = 1'b1;
    free_next = (SLOT_W + 1)'(SLOTS - int'(count_ones(16'(occ_next))));
    // NOTE: combinational logic uses blocking assignments so later lines
    // see the values computed above them within the same evaluation.
    resp_next.enter_ack  = enter_ok;
    resp_next.enter_err  = enter_req && !enter_ok;
    resp_next.exit_valid = exit_ok;
    resp_next.exit_err   = exit_req && !exit_ok;
  end

  // Slot storage, occupancy, timestamps and response pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the slot-time array is cleared on reset on purpose; a reset
      // must leave no stale entry time behind for a later exit to report.
      for (int i = 0; i < SLOTS; i++) slot_time[i] <= '0;
      occupied   <= '0;
      free_count <= (SLOT_W + 1)'(SLOTS);
      time_in    <= '0;
      time_out   <= '0;
      resp       <= '0;
    end else begin
      resp       <= resp_next;
      occupied   <= occ_next;
      free_count <= free_next;
      if (exit_ok) begin
        time_in  <= slot_time[exit_slot];
        time_out <= now;
      end
      if (enter_ok) slot_time[enter_slot] <= now;
    end
  end

  assign enter_ack  = resp.enter_ack;
  assign enter_err  = resp.enter_err;
  assign exit_valid = resp.exit_valid;
  assign exit_err   = resp.exit_err;

endmodule

// File: tb/tb_parking_time_recorder.sv
// Scoreboard bench for parking_time_recorder at default parameters.
module tb_parking_time_recorder;
  import parking_time_recorder_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              enter_req;
  logic [SLOT_W-1:0] enter_slot;
  logic              exit_req;
  logic [SLOT_W-1:0] exit_slot;
  logic              enter_ack;
  logic              enter_err;
  logic              exit_valid;
  logic              exit_err;
  logic [TW-1:0]     time_in;
  logic [TW-1:0]     time_out;
  logic [TW-1:0]     now;
  logic [SLOTS-1:0]  occupied;
  logic [SLOT_W:0]   free_count;

  parking_time_recorder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enter_req  (enter_req),
    .enter_slot (enter_slot),
    .exit_req   (exit_req),
    .exit_slot  (exit_slot),
    .enter_ack  (enter_ack),
    .enter_err  (enter_err),
    .exit_valid (exit_valid),
    .exit_err   (exit_err),
    .time_in    (time_in),
    .time_out   (time_out),
    .now        (now),
    .occupied   (occupied),
    .free_count (free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       pulses;   // {enter_ack, enter_err, exit_valid, exit_err}
    logic [TW-1:0]    tin;
    logic [TW-1:0]    tout;
    logic [TW-1:0]    tnow;
    logic [SLOTS-1:0] occ;
    logic [SLOT_W:0]  free;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model state
  int               m_presc;
  logic [TW-1:0]    m_now;
  logic [SLOTS-1:0] m_occ;
  logic [TW-1:0]    m_time [SLOTS];
  logic [TW-1:0]    m_tin;
  logic [TW-1:0]    m_tout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_presc = 0;
    m_now   = '0;
    m_occ   = '0;
    m_tin   = '0;
    m_tout  = '0;
    for (int i = 0; i < SLOTS; i++) m_time[i] = '0;
    sb_q.delete();
  endtask

  // Drive one cycle of requests, push the predicted response, then pop
  // and compare once the DUT has produced it.
  task automatic step(input logic en, input int es, input logic ex, input int xs);
    exp_t e;
    exp_t got_e;
    logic e_ok;
    logic x_ok;
    enter_req  = en;
    enter_slot = SLOT_W'(es);
    exit_req   = ex;
    exit_slot  = SLOT_W'(xs);
    e_ok = en && !m_occ[es];
    x_ok = ex && m_occ[xs];
    e.pulses = {e_ok, en && !e_ok, x_ok, ex && !x_ok};
    if (x_ok) begin
      m_tin     = m_time[xs];
      m_tout    = m_now;
      m_occ[xs] = 1'b0;
    end
    if (e_ok) begin
      m_time[es] = m_now;
      m_occ[es]  = 1'b1;
    end
    if (m_presc == TICK_DIV - 1) begin
      m_presc = 0;
      m_now   = m_now + TW'(1);
    end else begin
      m_presc++;
    end
    e.tin  = m_tin;
    e.tout = m_tout;
    e.tnow = m_now;
    e.occ  = m_occ;
    e.free = (SLOT_W + 1)'(SLOTS - $countones(m_occ));
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got_e = sb_q.pop_front();
    check("pulses",     {enter_ack, enter_err, exit_valid, exit_err}, got_e.pulses);
    check("time_in",    time_in,    got_e.tin);
    check("time_out",   time_out,   got_e.tout);
    check("now",        now,        got_e.tnow);
    check("occupied",   occupied,   got_e.occ);
    check("free_count", free_count, got_e.free);
  endtask

  task automatic idle_until(input int t);
    for (int i = 0; i < 2000 && m_now != TW'(t); i++) step(1'b0, 0, 1'b0, 0);
    check("reach_now", now, t);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    enter_req  = 1'b0;
    enter_slot = '0;
    exit_req   = 1'b0;
    exit_slot  = '0;
    model_reset();
    #12;
    // Reset state
    check("rst_occupied", occupied, 0);
    check("rst_free",     free_count, FREE_RESET);
    check("rst_now",      now, 0);
    check("rst_pulses",   {enter_ack, enter_err, exit_valid, exit_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle 40 cycles -> now = 10
    for (int i = 0; i < 40; i++) step(1'b0, 0, 1'b0, 0);
    check("idle_now", now, 10);

    // 2: basic enter at 5, exit at 17
    apply_reset();
    idle_until(5);
    step(1'b1, 2, 1'b0, 0);
    idle_until(17);
    step(1'b0, 0, 1'b1, 2);
    check("basic_tin",  time_in,  5);
    check("basic_tout", time_out, 17);
    check("basic_free", free_count, 8);

    // 3: wrap-around stay
    idle_until(250);
    step(1'b1, 7, 1'b0, 0);
    idle_until(4);
    step(1'b0, 0, 1'b1, 7);
    check("wrap_tin",  time_in,  250);
    check("wrap_tout", time_out, 4);
    check("wrap_diff", TW'(time_out - time_in), 10);

    // 4: double entry and exit from an empty slot
    step(1'b1, 3, 1'b0, 0);
    for (int i = 0; i < 9; i++) step(1'b0, 0, 1'b0, 0);
    step(1'b1, 3, 1'b0, 0);
    step(1'b0, 0, 1'b1, 5);
    step(1'b0, 0, 1'b1, 3);

    // 5: simultaneous requests
    step(1'b1, 1, 1'b0, 0);
    step(1'b1, 6, 1'b0, 0);
    for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b0, 0);
    step(1'b1, 1, 1'b1, 1);   // occupied: exit wins, enter_err
    step(1'b1, 4, 1'b1, 6);   // different slots: both succeed
    step(1'b1, 0, 1'b1, 0);   // free: enter wins, exit_err
    step(1'b1, 5, 1'b1, 5);   // held-style repeat pattern on another slot
    step(1'b1, 5, 1'b1, 5);   // now occupied: exit wins

    // 6: fill every slot, then reset mid-cycle
    for (int i = 0; i < SLOTS; i++) step(1'b1, i, 1'b0, 0);
    check("full_free", free_count, 0);
    check("full_occ",  occupied, 8'hff);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_occ",    occupied, 0);
    check("midrst_free",   free_count, 8);
    check("midrst_now",    now, 0);
    check("midrst_tin",    time_in, 0);
    check("midrst_tout",   time_out, 0);
    check("midrst_pulses", {enter_ack, enter_err, exit_valid, exit_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 0, 1'b0, 0);
    check("post_now",  now, 0);
    check("post_free", free_count, 8);
    // Stored times must not survive reset: re-enter and exit slot 2
    idle_until(3);
    step(1'b1, 2, 1'b0, 0);
    step(1'b0, 0, 1'b1, 2);
    check("post_tin", time_in, 3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/parking_time_recorder.md
Name: parking_time_recorder

Overview:
Produces the entry/exit timestamp pair consumed by the time-difference subtractor in the parking system.
- Keeps a prescaled 8-bit time base.
- Stores the entry time per parking slot.
- On an exit event, presents the stored entry time and the current time as time_in / time_out, with a one-cycle valid pulse.
- Tracks slot occupancy and free-slot count for the capacity logic.

Parameters:
SLOTS, 8, number of parking slots (power of two, 2..16)
SLOT_W, 3, slot index width, equal to log2(SLOTS)
TICK_DIV, 4, clock cycles per time unit (>= 1)
TW, 8, timestamp width

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enter_req  in  1  car-entry event, sampled each rising edge
enter_slot  in  SLOT_W  slot index for entry
exit_req  in  1  car-exit event, sampled each rising edge
exit_slot  in  SLOT_W  slot index for exit
enter_ack  out  1  one-cycle pulse: entry accepted
enter_err  out  1  one-cycle pulse: entry rejected (slot already occupied)
exit_valid  out  1  one-cycle pulse: time_in/time_out are valid
exit_err  out  1  one-cycle pulse: exit rejected (slot empty)
time_in  out  TW  stored entry time of the exiting slot
time_out  out  TW  time base value at exit
now  out  TW  current time base
occupied  out  SLOTS  per-slot occupancy flags
free_count  out  SLOT_W+1  number of free slots

Behaviour:
Reset:
- rst_n low clears, asynchronously: prescaler, now, all slot registers, occupied, time_in, time_out, and all pulse outputs.
- free_count resets to SLOTS.
- Reset asserted mid-operation discards all pending and stored state immediately; there is no partial result.

Time base:
- Prescaler counts 0..TICK_DIV-1.
- On the edge where the prescaler equals TICK_DIV-1: prescaler returns to 0 and now increments by 1 modulo 2^TW (255 -> 0, no saturation).
- With TICK_DIV=1, now increments every cycle.

Timestamp sampling:
- Entry and exit both use the value of now before the edge (pre-increment value).
- This holds even on an edge where now increments.

Entry (evaluated against occupancy before the edge):
- If occupied[enter_slot]=0: store now in slot, set occupied, pulse enter_ack on the next cycle.
- Otherwise: no state change, pulse enter_err.

Exit (evaluated against occupancy before the edge):
- If occupied[exit_slot]=1: load time_in with the stored slot time and time_out with now, clear occupied, pulse exit_valid.
- Otherwise: pulse exit_err; time_in/time_out are unchanged.

Latency and holding:
- Latency is exactly 1 cycle from the request edge to the response pulse.
- time_in/time_out hold until the next successful exit.

Request rules:
- Each request is a single-cycle event with no backpressure; a held request is re-evaluated every cycle.
- Enter and exit on different slots in the same cycle: both are processed.
- Enter and exit on the same slot in the same cycle, slot occupied: exit succeeds, enter_err.
- Enter and exit on the same slot in the same cycle, slot free: enter succeeds, exit_err.

Counts and arithmetic:
- free_count = SLOTS minus the population count of occupied; it updates in the same cycle as occupied.
- Downstream time_out - time_in modulo 2^TW is correct for stays shorter than 2^TW time units. Longer stays alias; this is documented, not flagged.

Decomposition:
- Shared package: TW, SLOTS, SLOT_W, TICK_DIV defaults, and the reset value of free_count.
- Sub-module time_base: prescaler plus the now counter, with outputs now and tick.
- Slot storage and request logic stay in the top module.

Test Plan:
1. Reset, then idle 40 cycles with TICK_DIV=4 -> now=10; occupied=0; free_count=8; no pulses.
2. Enter slot 2 at now=5; exit slot 2 at now=17 -> enter_ack one cycle later; exit_valid with time_in=5, time_out=17; occupied[2]=0; free_count back to 8.
3. Wrap: enter slot 7 at now=250; exit at now=4 -> time_in=250, time_out=4; downstream difference equals 10.
4. Enter slot 3 twice -> second request gives enter_err, stored time unchanged. Exit slot 5 while empty -> exit_err, time_in/time_out keep previous values.
5. Simultaneous, same cycle:
   - Enter slot 1 and exit slot 1, slot occupied -> exit_valid and enter_err.
   - Enter slot 4 and exit slot 6, both legal -> enter_ack and exit_valid.
6. Fill all 8 slots -> free_count=0. Assert rst_n low mid-cycle -> outputs clear immediately; after release, free_count=8 and now=0.
